// File: rtl/risc16_pkg.sv
// RiSC-16 shared definitions: widths, opcodes, next-PC selects, fetch FSM states.
package risc16_pkg;

  localparam int RISC16_WIDTH = 16;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_ADDI = 3'b001;
  localparam logic [2:0] OP_NAND = 3'b010;
  localparam logic [2:0] OP_LUI  = 3'b011;
  localparam logic [2:0] OP_SW   = 3'b100;
  localparam logic [2:0] OP_LW   = 3'b101;
  localparam logic [2:0] OP_BEQ  = 3'b110;
  localparam logic [2:0] OP_JALR = 3'b111;

  // 2'b11 is reserved and behaves like PCSEL_INC
  localparam logic [1:0] PCSEL_INC = 2'b00;
  localparam logic [1:0] PCSEL_BR  = 2'b01;
  localparam logic [1:0] PCSEL_ALU = 2'b10;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'b00,
    ST_FETCH = 2'b01,
    ST_HOLD  = 2'b10,
    ST_ERR   = 2'b11
  } fetch_state_t;

endpackage

// File: rtl/pc_next.sv
// Next-PC mux/adder: PC+1, PC+1+imm or alu target, all modulo 2^WIDTH.
// Purely combinational, zero latency; no handshake, caller decides when to sample.
module pc_next
  import risc16_pkg::*;
#(
  parameter int WIDTH = RISC16_WIDTH
) (
  input  logic [WIDTH-1:0] pc,
  input  logic [1:0]       pc_sel,
  input  logic [WIDTH-1:0] imm_ext,
  input  logic [WIDTH-1:0] alu_out,
  output logic [WIDTH-1:0] next_pc,
  output logic [WIDTH-1:0] pc_plus1
);

  assign pc_plus1 = pc + WIDTH'(1);

  always_comb begin
    next_pc = pc_plus1;
    case (pc_sel)
      PCSEL_BR:  next_pc = pc_plus1 + imm_ext;
      PCSEL_ALU: next_pc = alu_out;
      default:   next_pc = pc_plus1;
    endcase
  end

endmodule

// File: rtl/fetch_unit.sv
// RiSC-16 fetch: PC/IR owner, req/ack imem fetch; ack N -> ins_valid N+1, exec_done M -> new req M+1.
// imem_req held (address stable) until ack; FETCH_TIMEOUT_EN adds a sticky fetch_err after TIMEOUT unacked cycles.
module fetch_unit
  import risc16_pkg::*;
#(
  parameter int               WIDTH    = RISC16_WIDTH,
  parameter logic [WIDTH-1:0] RESET_PC = '0,
  parameter int               TIMEOUT  = 15
) (
  input  logic             clk,
  input  logic             rst,
  output logic             imem_req,
  output logic [WIDTH-1:0] imem_addr,
  input  logic             imem_ack,
  input  logic [WIDTH-1:0] imem_rdata,
  output logic             ins_valid,
  output logic [WIDTH-1:0] ins_out,
  output logic [2:0]       op,
  output logic [WIDTH-1:0] pc_plus1,
  input  logic             exec_done,
  input  logic [1:0]       pc_sel,
  input  logic [WIDTH-1:0] imm_ext,
  input  logic [WIDTH-1:0] alu_out,
  output logic             fetch_err
);

  fetch_state_t     state;
  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] ir;
  logic [WIDTH-1:0] next_pc;

  pc_next #(.WIDTH(WIDTH)) u_pc_next (
    .pc       (pc),
    .pc_sel   (pc_sel),
    .imm_ext  (imm_ext),
    .alu_out  (alu_out),
    .next_pc  (next_pc),
    .pc_plus1 (pc_plus1)
  );

`ifdef FETCH_TIMEOUT_EN
  localparam int             CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  logic [CNT_W-1:0] wait_cnt;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_BOOT;
      pc    <= RESET_PC;
      ir    <= '0;
`ifdef FETCH_TIMEOUT_EN
      wait_cnt <= '0;
`endif
    end else begin
      case (state)
        ST_BOOT: begin
          state <= ST_FETCH;
`ifdef FETCH_TIMEOUT_EN
          wait_cnt <= '0;
`endif
        end
        ST_FETCH: begin
          // An ack arriving on the last allowed cycle still wins over the timeout
          if (imem_ack) begin
            ir    <= imem_rdata;
            state <= ST_HOLD;
          end
`ifdef FETCH_TIMEOUT_EN
          else if (wait_cnt == CNT_LAST) begin
            state <= ST_ERR;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
`endif
        end
        ST_HOLD: begin
          if (exec_done) begin
            pc    <= next_pc;
            state <= ST_FETCH;
`ifdef FETCH_TIMEOUT_EN
            wait_cnt <= '0;
`endif
          end
        end
`ifdef FETCH_TIMEOUT_EN
        ST_ERR: state <= ST_ERR;
`endif
        default: state <= ST_BOOT;
      endcase
    end
  end

  assign imem_req  = (state == ST_FETCH);
  assign imem_addr = pc;
  assign ins_valid = (state == ST_HOLD);
  assign ins_out   = ir;
  assign op        = ir[WIDTH-1 -: 3];

`ifdef FETCH_TIMEOUT_EN
  assign fetch_err = (state == ST_ERR);
`else
  assign fetch_err = 1'b0;
`endif

endmodule
